perceptron_train_ctrl: RTL and testbench

PERCEPTRON_TRAIN_CTRL -- requirements
Module: perceptron_train_ctrl

---
 rtl/perceptron_pkg.sv | 24 ++
 rtl/perceptron_train_ctrl_if.sv | 25 ++
 rtl/sample_buf.sv | 25 ++
 rtl/perceptron_train_ctrl.sv | 151 +++++++++++++++
 tb/tb_perceptron_train_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/perceptron_pkg.sv
// Perceptron training controller shared types.
// State encoding, sample layout and default sizing.
package perceptron_pkg;

    localparam int DEF_NUM_SAMPLES = 8;
    localparam int DEF_MAX_EPOCHS  = 15;
    localparam int DEF_PCPT_LAT    = 1;
    localparam int FEAT_W          = 8;

    typedef enum logic [2:0] {
        IDLE,
        PRESENT,
        WAIT,
        CHECK,
        EPOCH_END,
        DONE
    } state_t;

    typedef struct packed {
        logic [FEAT_W-1:0] data;
        logic              exp;
    } sample_t;

endpackage

// File: rtl/perceptron_train_ctrl_if.sv
// Sample load port and perceptron drive/return port.
// slave is the controller side, master is the host/perceptron side.
interface perceptron_train_ctrl_if;
    import perceptron_pkg::*;

    logic              load_valid;
    logic [FEAT_W-1:0] load_data;
    logic              load_exp;
    logic              load_ready;
    logic [FEAT_W-1:0] pcpt_in;
    logic              pcpt_exp;
    logic              pcpt_learn;
    logic              pcpt_result;

    modport master (
        output load_valid, load_data, load_exp, pcpt_result,
        input  load_ready, pcpt_in, pcpt_exp, pcpt_learn
    );

    modport slave (
        input  load_valid, load_data, load_exp, pcpt_result,
        output load_ready, pcpt_in, pcpt_exp, pcpt_learn
    );

endinterface

// File: rtl/sample_buf.sv
// Training sample register file.
// One write port, one asynchronous read port, no reset.
module sample_buf
    import perceptron_pkg::*;
#(
    parameter int DEPTH = DEF_NUM_SAMPLES,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  sample_t       wdata,
    input  logic [AW-1:0] raddr,
    output sample_t       rdata
);

    sample_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Perceptron training sequencer: buffers samples, replays them
// each epoch until an error-free epoch or the epoch limit.
module perceptron_train_ctrl
    import perceptron_pkg::*;
#(
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
    parameter int MAX_EPOCHS  = DEF_MAX_EPOCHS,
    parameter int PCPT_LAT    = DEF_PCPT_LAT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    start,
    perceptron_train_ctrl_if.slave  bus,
    output logic                    busy,
    output logic                    done,
    output logic                    converged,
    output logic [3:0]              epoch_cnt,
    output logic [4:0]              err_cnt
);

    localparam int AW = $clog2(NUM_SAMPLES);
    localparam int CW = AW + 1;

    state_t        state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [AW-1:0] idx, idx_nxt;
    logic [1:0]    wcnt, wcnt_nxt;
    logic [3:0]    epoch_nxt;
    logic [4:0]    err_nxt;
    logic          conv_nxt;
    logic          wr;
    logic          active;
    sample_t       wd, rd;

    sample_buf #(
        .DEPTH (NUM_SAMPLES),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (wr),
        .waddr (count[AW-1:0]),
        .wdata (wd),
        .raddr (idx),
        .rdata (rd)
    );

    assign wd     = {bus.load_data, bus.load_exp};
    assign active = (state == PRESENT) || (state == WAIT)
                 || (state == CHECK);

    // Gated by rst_n so every output reads 0 while reset is held.
    assign bus.load_ready = rst_n
                         && ((state == IDLE) || (state == DONE))
                         && (count < CW'(NUM_SAMPLES));
    assign wr             = bus.load_valid && bus.load_ready;
    assign bus.pcpt_in    = active ? rd.data : '0;
    assign bus.pcpt_exp   = active ? rd.exp : 1'b0;
    assign bus.pcpt_learn = (state == PRESENT);
    assign busy           = active || (state == EPOCH_END);
    assign done           = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            idx       <= '0;
            wcnt      <= '0;
            epoch_cnt <= '0;
            err_cnt   <= '0;
            converged <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            idx       <= idx_nxt;
            wcnt      <= wcnt_nxt;
            epoch_cnt <= epoch_nxt;
            err_cnt   <= err_nxt;
            converged <= conv_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        idx_nxt   = idx;
        wcnt_nxt  = wcnt;
        epoch_nxt = epoch_cnt;
        err_nxt   = err_cnt;
        conv_nxt  = converged;

        if (wr) count_nxt = count + CW'(1);

        unique case (state)
            IDLE, DONE: begin
                // A write landing with start joins this run.
                if (start && (count_nxt != '0)) begin
                    state_nxt = PRESENT;
                    idx_nxt   = '0;
                    err_nxt   = '0;
                    epoch_nxt = '0;
                    conv_nxt  = 1'b0;
                end
            end
            PRESENT: begin
                wcnt_nxt  = '0;
                state_nxt = (PCPT_LAT > 1) ? WAIT : CHECK;
            end
            WAIT: begin
                if (int'(wcnt) >= PCPT_LAT - 2) state_nxt = CHECK;
                else wcnt_nxt = wcnt + 2'd1;
            end
            CHECK: begin
                if (bus.pcpt_result != rd.exp) begin
                    err_nxt = err_cnt + 5'd1;
                end
                if (CW'(idx) == count - CW'(1)) begin
                    state_nxt = EPOCH_END;
                end else begin
                    idx_nxt   = idx + AW'(1);
                    state_nxt = PRESENT;
                end
            end
            EPOCH_END: begin
                epoch_nxt = epoch_cnt + 4'd1;
                if (err_cnt == '0) begin
                    state_nxt = DONE;
                    conv_nxt  = 1'b1;
                end else if (epoch_cnt + 4'd1 == 4'(MAX_EPOCHS)) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = '0;
                    err_nxt   = '0;
                    state_nxt = PRESENT;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (clr) begin
            state_nxt = IDLE;
            count_nxt = '0;
            idx_nxt   = '0;
            wcnt_nxt  = '0;
            epoch_nxt = '0;
            err_nxt   = '0;
            conv_nxt  = 1'b0;
        end
    end

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Directed bench for perceptron_train_ctrl: a default-sized instance
// and a MAX_EPOCHS=3 / PCPT_LAT=3 instance, each with a perceptron stub.
module tb_perceptron_train_ctrl;
    import perceptron_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    perceptron_train_ctrl_if a_if ();
    perceptron_train_ctrl_if b_if ();

    logic       a_start, a_clr, a_busy, a_done, a_conv;
    logic [3:0] a_epoch;
    logic [4:0] a_err;
    logic       b_start, b_clr, b_busy, b_done, b_conv;
    logic [3:0] b_epoch;
    logic [4:0] b_err;

    perceptron_train_ctrl dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (a_clr),
        .start     (a_start),
        .bus       (a_if),
        .busy      (a_busy),
        .done      (a_done),
        .converged (a_conv),
        .epoch_cnt (a_epoch),
        .err_cnt   (a_err)
    );

    perceptron_train_ctrl #(
        .NUM_SAMPLES (8),
        .MAX_EPOCHS  (3),
        .PCPT_LAT    (3)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (b_clr),
        .start     (b_start),
        .bus       (b_if),
        .busy      (b_busy),
        .done      (b_done),
        .converged (b_conv),
        .epoch_cnt (b_epoch),
        .err_cnt   (b_err)
    );

    // Stubs: answer exactly PCPT_LAT cycles after learn, the inverse otherwise.
    logic       a_lv = 1'b0, a_ev = 1'b0, a_wrong = 1'b0;
    logic [2:0] b_lv = '0, b_ev = '0;
    logic       b_wrong = 1'b0;
    int         a_pulses = 0, b_pulses = 0;

    always @(posedge clk) begin
        a_lv <= a_if.pcpt_learn;
        a_ev <= a_if.pcpt_exp;
        b_lv <= {b_lv[1:0], b_if.pcpt_learn};
        b_ev <= {b_ev[1:0], b_if.pcpt_exp};
        if (a_if.pcpt_learn) a_pulses <= a_pulses + 1;
        if (b_if.pcpt_learn) b_pulses <= b_pulses + 1;
    end

    assign a_if.pcpt_result = a_lv ? (a_ev ^ a_wrong)
                                   : ~(a_if.pcpt_exp ^ a_wrong);
    assign b_if.pcpt_result = b_lv[2] ? (b_ev[2] ^ b_wrong)
                                      : ~(b_if.pcpt_exp ^ b_wrong);

    int passed = 0;
    int total = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] d, input logic e);
        a_if.load_valid = 1'b1;
        a_if.load_data  = d;
        a_if.load_exp   = e;
        tick();
        a_if.load_valid = 1'b0;
    endtask

    task automatic load_b(input logic [7:0] d, input logic e);
        b_if.load_valid = 1'b1;
        b_if.load_data  = d;
        b_if.load_exp   = e;
        tick();
        b_if.load_valid = 1'b0;
    endtask

    task automatic wait_a(output int n);
        n = 0;
        while (!a_done && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_b(output int n);
        n = 0;
        while (!b_done && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int p0;
        a_start = 0; a_clr = 0;
        b_start = 0; b_clr = 0;
        a_if.load_valid = 0; a_if.load_data = '0; a_if.load_exp = 0;
        b_if.load_valid = 0; b_if.load_data = '0; b_if.load_exp = 0;

        // Reset
        #12;
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_ready_held", 32'(a_if.load_ready), 0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", 32'(a_if.load_ready), 1);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_epoch", 32'(a_epoch), 0);
        chk("rst_err", 32'(a_err), 0);
        chk("rst_pin", 32'(a_if.pcpt_in), 0);
        chk("rst_learn", 32'(a_if.pcpt_learn), 0);

        // Four samples, ideal perceptron: converge in one epoch
        load_a(8'h11, 1'b1);
        load_a(8'h22, 1'b0);
        load_a(8'h33, 1'b1);
        load_a(8'h44, 1'b0);
        a_start = 1'b1; tick(); a_start = 1'b0;
        chk("p_learn", 32'(a_if.pcpt_learn), 1);
        chk("p_in", 32'(a_if.pcpt_in), 32'h11);
        chk("p_exp", 32'(a_if.pcpt_exp), 1);
        chk("p_busy", 32'(a_busy), 1);
        tick();
        chk("c_learn", 32'(a_if.pcpt_learn), 0);
        chk("c_hold_in", 32'(a_if.pcpt_in), 32'h11);
        tick();
        chk("p2_in", 32'(a_if.pcpt_in), 32'h22);
        chk("p2_exp", 32'(a_if.pcpt_exp), 0);
        wait_a(n);
        chk("ideal_cycles", 32'(n + 2), 9);
        chk("ideal_conv", 32'(a_conv), 1);
        chk("ideal_epoch", 32'(a_epoch), 1);
        chk("ideal_err", 32'(a_err), 0);
        chk("ideal_busy", 32'(a_busy), 0);
        chk("ideal_pin_done", 32'(a_if.pcpt_in), 0);

        // Write coinciding with start joins the run
        a_clr = 1'b1; tick(); a_clr = 1'b0;
        chk("clr_done", 32'(a_done), 0);
        load_a(8'h55, 1'b1);
        load_a(8'h66, 1'b0);
        p0 = a_pulses;
        a_if.load_valid = 1'b1;
        a_if.load_data  = 8'h77;
        a_if.load_exp   = 1'b1;
        a_start = 1'b1; tick();
        a_start = 1'b0; a_if.load_valid = 1'b0;
        chk("join_in", 32'(a_if.pcpt_in), 32'h55);
        wait_a(n);
        chk("join_cycles", 32'(n), 7);
        chk("join_pulses", 32'(a_pulses - p0), 3);
        chk("join_conv", 32'(a_conv), 1);

        // Nine writes with load_valid held: eight accepted
        a_clr = 1'b1; tick(); a_clr = 1'b0;
        a_if.load_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            a_if.load_data = 8'(8'hA0 + i);
            a_if.load_exp  = i[0];
            chk("fill_ready", 32'(a_if.load_ready), 32'(i < 8));
            tick();
        end
        a_if.load_valid = 1'b0;
        chk("full_ready", 32'(a_if.load_ready), 0);
        p0 = a_pulses;
        a_start = 1'b1; tick(); a_start = 1'b0;
        chk("full_first_in", 32'(a_if.pcpt_in), 32'hA0);
        wait_a(n);
        chk("full_cycles", 32'(n), 17);
        chk("full_pulses", 32'(a_pulses - p0), 8);
        chk("full_conv", 32'(a_conv), 1);

        // PCPT_LAT=3, result valid only in the sampling cycle
        load_b(8'h5A, 1'b1);
        load_b(8'hC3, 1'b0);
        p0 = b_pulses;
        b_start = 1'b1; tick(); b_start = 1'b0;
        chk("lat_learn", 32'(b_if.pcpt_learn), 1);
        chk("lat_in", 32'(b_if.pcpt_in), 32'h5A);
        tick();
        chk("lat_wait_learn", 32'(b_if.pcpt_learn), 0);
        chk("lat_wait_in", 32'(b_if.pcpt_in), 32'h5A);
        wait_b(n);
        chk("lat_cycles", 32'(n + 1), 9);
        chk("lat_conv", 32'(b_conv), 1);
        chk("lat_epoch", 32'(b_epoch), 1);
        chk("lat_err", 32'(b_err), 0);
        chk("lat_pulses", 32'(b_pulses - p0), 2);

        // Always-wrong perceptron: give up after MAX_EPOCHS=3
        b_wrong = 1'b1;
        p0 = b_pulses;
        b_start = 1'b1; tick(); b_start = 1'b0;
        chk("wrong_done_clr", 32'(b_done), 0);
        chk("wrong_busy", 32'(b_busy), 1);
        wait_b(n);
        chk("wrong_cycles", 32'(n), 27);
        chk("wrong_conv", 32'(b_conv), 0);
        chk("wrong_epoch", 32'(b_epoch), 3);
        chk("wrong_err", 32'(b_err), 2);
        chk("wrong_pulses", 32'(b_pulses - p0), 6);

        // clr in WAIT of epoch 2
        b_start = 1'b1; tick(); b_start = 1'b0;
        repeat (10) tick();
        chk("mid_epoch", 32'(b_epoch), 1);
        chk("mid_busy", 32'(b_busy), 1);
        chk("mid_wait_learn", 32'(b_if.pcpt_learn), 0);
        b_clr = 1'b1; tick(); b_clr = 1'b0;
        chk("clr_busy", 32'(b_busy), 0);
        chk("clr_epoch", 32'(b_epoch), 0);
        chk("clr_err", 32'(b_err), 0);
        chk("clr_learn", 32'(b_if.pcpt_learn), 0);
        chk("clr_ready", 32'(b_if.load_ready), 1);
        b_start = 1'b1; tick(); b_start = 1'b0;
        tick();
        chk("empty_start_busy", 32'(b_busy), 0);
        chk("empty_start_learn", 32'(b_if.pcpt_learn), 0);
        load_b(8'h0F, 1'b0);
        b_start = 1'b1; tick(); b_start = 1'b0;
        chk("reload_learn", 32'(b_if.pcpt_learn), 1);
        chk("reload_in", 32'(b_if.pcpt_in), 32'h0F);

        // Asynchronous reset mid-PRESENT
        a_start = 1'b1; tick(); a_start = 1'b0;
        chk("pre_rst_learn", 32'(a_if.pcpt_learn), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(a_busy), 0);
        chk("arst_learn", 32'(a_if.pcpt_learn), 0);
        chk("arst_pin", 32'(a_if.pcpt_in), 0);
        chk("arst_ready", 32'(a_if.load_ready), 0);
        chk("arst_conv", 32'(a_conv), 0);
        chk("arst_epoch", 32'(a_epoch), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(a_if.load_ready), 1);
        chk("post_rst_done", 32'(a_done), 0);
        a_start = 1'b1; tick(); a_start = 1'b0;
        chk("post_rst_start", 32'(a_busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
